// File: rtl/ula_pkg.sv
// Shared types and constants for the multi-byte ALU sequencer.
package ula_pkg;

    // Width of one ALU slice.
    localparam int ULA_BYTE_W = 8;

    // Carry lines are active-low, as on the 74181.
    localparam logic ULA_CARRY_ASSERTED = 1'b0;
    localparam logic ULA_CARRY_NONE     = 1'b1;

    // Sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } ula_state_t;

endpackage : ula_pkg

// File: rtl/ula_8_bits.sv
// 8-bit 74181-style ALU. Data is active-high; carry in/out are active-low.
// Arithmetic mode computes op1 + op2 + carry, where op1/op2 are the
// select-gated terms of the 74181; logic mode uses the 74181 logic table.
// Carry out always reflects the arithmetic chain, even in logic mode.
module ula_8_bits
    import ula_pkg::*;
(
    input  logic [ULA_BYTE_W-1:0] i_a,
    input  logic [ULA_BYTE_W-1:0] i_b,
    input  logic [3:0]            i_s,
    input  logic                  i_m,
    input  logic                  i_c_in,
    output logic [ULA_BYTE_W-1:0] o_f,
    output logic                  o_c_out,
    output logic                  o_a_eq_b
);

    logic [ULA_BYTE_W-1:0] w_op1;
    logic [ULA_BYTE_W-1:0] w_op2;
    logic [ULA_BYTE_W:0]   w_sum;
    logic [ULA_BYTE_W-1:0] w_logic;
    logic                  w_carry;

    // Arithmetic path: the two 74181 propagate/generate operand terms plus carry.
    always_comb begin
        w_op1   = i_a | (i_b & {ULA_BYTE_W{i_s[0]}}) | (~i_b & {ULA_BYTE_W{i_s[1]}});
        w_op2   = (i_a & ~i_b & {ULA_BYTE_W{i_s[2]}}) | (i_a & i_b & {ULA_BYTE_W{i_s[3]}});
        w_carry = (i_c_in == ULA_CARRY_ASSERTED);
        w_sum   = {1'b0, w_op1} + {1'b0, w_op2} + {{ULA_BYTE_W{1'b0}}, w_carry};
    end

    // Logic path: the sixteen bitwise functions of the 74181.
    always_comb begin
        w_logic = '0;
        case (i_s)
            4'b0000: w_logic = ~i_a;
            4'b0001: w_logic = ~(i_a | i_b);
            4'b0010: w_logic = ~i_a & i_b;
            4'b0011: w_logic = '0;
            4'b0100: w_logic = ~(i_a & i_b);
            4'b0101: w_logic = ~i_b;
            4'b0110: w_logic = i_a ^ i_b;
            4'b0111: w_logic = i_a & ~i_b;
            4'b1000: w_logic = ~i_a | i_b;
            4'b1001: w_logic = ~(i_a ^ i_b);
            4'b1010: w_logic = i_b;
            4'b1011: w_logic = i_a & i_b;
            4'b1100: w_logic = '1;
            4'b1101: w_logic = i_a | ~i_b;
            4'b1110: w_logic = i_a | i_b;
            default: w_logic = i_a;
        endcase
    end

    // Output select; A=B is the AND of all result bits, as on the 74181.
    always_comb begin
        o_f      = i_m ? w_logic : w_sum[ULA_BYTE_W-1:0];
        o_c_out  = w_sum[ULA_BYTE_W] ? ULA_CARRY_ASSERTED : ULA_CARRY_NONE;
        o_a_eq_b = &o_f;
    end

endmodule : ula_8_bits

// File: rtl/ula_seq_exec.sv
// Multi-byte execution sequencer: runs one NBYTES-wide operation through a
// single 8-bit ALU, LSB byte first, chaining the active-low carry.
// Handshakes: a transfer happens on a rising clk edge where valid & ready are
// both high; a producer holds valid and its payload until that edge.
module ula_seq_exec
    import ula_pkg::*;
#(
    parameter int NBYTES = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [ULA_BYTE_W*NBYTES-1:0] cmd_a,
    input  logic [ULA_BYTE_W*NBYTES-1:0] cmd_b,
    input  logic [3:0]                   cmd_s,
    input  logic                         cmd_m,
    input  logic                         cmd_c_in,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [ULA_BYTE_W*NBYTES-1:0] res_f,
    output logic                         res_c_out,
    output logic                         res_a_eq_b,
    output logic                         busy
);

    localparam int W    = ULA_BYTE_W * NBYTES;
    localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

    ula_state_t r_state;
    ula_state_t w_next_state;

    logic [IDXW-1:0] r_idx;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [3:0]      r_s;
    logic            r_m;
    logic            r_carry;
    logic            r_eq;
    logic [W-1:0]    r_work_f;

    logic            r_res_valid;
    logic [W-1:0]    r_res_f;
    logic            r_res_c_out;
    logic            r_res_eq;

    logic                  w_cmd_ready;
    logic                  w_busy;
    logic                  w_last;
    logic [ULA_BYTE_W-1:0] w_a_byte;
    logic [ULA_BYTE_W-1:0] w_b_byte;
    logic [ULA_BYTE_W-1:0] w_alu_f;
    logic                  w_alu_c_out;
    logic                  w_alu_eq;
    logic [W-1:0]          w_final_f;

    assign w_last = (r_idx == LAST_IDX);

    // Select the operand bytes for the current slice.
    always_comb begin
        w_a_byte = '0;
        w_b_byte = '0;
        for (int k = 0; k < NBYTES; k++) begin
            if (r_idx == IDXW'(k)) begin
                w_a_byte = r_a[k*ULA_BYTE_W +: ULA_BYTE_W];
                w_b_byte = r_b[k*ULA_BYTE_W +: ULA_BYTE_W];
            end
        end
    end

    // The single ALU, time-multiplexed across all bytes.
    ula_8_bits u_alu (
        .i_a      (w_a_byte),
        .i_b      (w_b_byte),
        .i_s      (r_s),
        .i_m      (r_m),
        .i_c_in   (r_carry),
        .o_f      (w_alu_f),
        .o_c_out  (w_alu_c_out),
        .o_a_eq_b (w_alu_eq)
    );

    // Working result with the current slice merged in, used on the last byte.
    always_comb begin
        w_final_f = r_work_f;
        for (int k = 0; k < NBYTES; k++) begin
            if (r_idx == IDXW'(k)) begin
                w_final_f[k*ULA_BYTE_W +: ULA_BYTE_W] = w_alu_f;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        w_next_state = r_state;
        w_cmd_ready  = 1'b0;
        w_busy       = 1'b1;
        case (r_state)
            ST_IDLE: begin
                w_cmd_ready = 1'b1;
                w_busy      = 1'b0;
                if (cmd_valid) begin
                    w_next_state = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (w_last) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Datapath: command latch, per-byte accumulation and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_s         <= '0;
            r_m         <= 1'b0;
            r_carry     <= 1'b0;
            r_eq        <= 1'b0;
            r_work_f    <= '0;
            r_res_valid <= 1'b0;
            r_res_f     <= '0;
            r_res_c_out <= ULA_CARRY_NONE;
            r_res_eq    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_a     <= cmd_a;
                        r_b     <= cmd_b;
                        r_s     <= cmd_s;
                        r_m     <= cmd_m;
                        r_carry <= cmd_c_in;
                        r_eq    <= 1'b1;
                        r_idx   <= '0;
                    end
                end
                ST_EXEC: begin
                    for (int k = 0; k < NBYTES; k++) begin
                        if (r_idx == IDXW'(k)) begin
                            r_work_f[k*ULA_BYTE_W +: ULA_BYTE_W] <= w_alu_f;
                        end
                    end
                    r_carry <= w_alu_c_out;
                    r_eq    <= r_eq & w_alu_eq;
                    if (w_last) begin
                        r_idx       <= '0;
                        r_res_f     <= w_final_f;
                        r_res_c_out <= w_alu_c_out;
                        r_res_eq    <= r_eq & w_alu_eq;
                        r_res_valid <= 1'b1;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                    end
                end
                default: begin
                    r_res_valid <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready  = w_cmd_ready;
    assign busy       = w_busy;
    assign res_valid  = r_res_valid;
    assign res_f      = r_res_f;
    assign res_c_out  = r_res_c_out;
    assign res_a_eq_b = r_res_eq;

endmodule : ula_seq_exec

// File: tb/tb_ula_seq_exec.sv
// Directed bench for ula_seq_exec with NBYTES = 2.
module tb_ula_seq_exec;

    localparam int NB = 2;
    localparam int W  = 8 * NB;
    localparam int EW = W + 2;

    logic         clk;
    logic         rst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [W-1:0] cmd_a;
    logic [W-1:0] cmd_b;
    logic [3:0]   cmd_s;
    logic         cmd_m;
    logic         cmd_c_in;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_f;
    logic         res_c_out;
    logic         res_a_eq_b;
    logic         busy;

    int n_total;
    int n_bad;

    // expected {f, c_out, a_eq_b} per issued command
    logic [EW-1:0] exp_q[$];

    ula_seq_exec #(.NBYTES(NB)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_s      (cmd_s),
        .cmd_m      (cmd_m),
        .cmd_c_in   (cmd_c_in),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_f      (res_f),
        .res_c_out  (res_c_out),
        .res_a_eq_b (res_a_eq_b),
        .busy       (busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got=running exp=finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Present a command and hold it until accepted; returns #1 after the accept edge.
    task automatic send_cmd(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [3:0] s, input logic m, input logic c);
        int waited;
        cmd_a = a; cmd_b = b; cmd_s = s; cmd_m = m; cmd_c_in = c;
        cmd_valid = 1'b1;
        waited = 0;
        while (!cmd_ready && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!cmd_ready) check("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_a = W'($urandom);
        cmd_b = W'($urandom);
    endtask

    // Called #1 after the accept edge; checks latency and busy on the way.
    task automatic wait_result(input string tag);
        int lat;
        lat = 0;
        check({tag, "_busy_T"}, 32'(busy), 32'd1);
        while (!res_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (!res_valid) check({tag, "_busy_exec"}, 32'(busy), 32'd1);
        end
        check({tag, "_latency"}, 32'(lat), 32'(NB));
        check({tag, "_busy_done"}, 32'(busy), 32'd1);
    endtask

    // Compare the presented result against the scoreboard head.
    task automatic compare_result(input string tag);
        logic [EW-1:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_f"},   32'(res_f),      32'(e[EW-1:2]));
            check({tag, "_c"},   32'(res_c_out),  32'(e[1]));
            check({tag, "_eq"},  32'(res_a_eq_b), 32'(e[0]));
        end
    endtask

    // Take the result and confirm the block returns to idle with data held.
    task automatic consume(input string tag);
        logic [W-1:0] held;
        held = res_f;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        check({tag, "_valid_drop"}, 32'(res_valid), 32'd0);
        check({tag, "_idle"},       32'(busy),      32'd0);
        check({tag, "_f_held"},     32'(res_f),     32'(held));
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [3:0] s, input logic m, input logic c,
                          input logic [W-1:0] ef, input logic ec, input logic eeq);
        exp_q.push_back({ef, ec, eeq});
        send_cmd(a, b, s, m, c);
        wait_result(tag);
        compare_result(tag);
        consume(tag);
    endtask

    initial begin
        logic [W-1:0] snap_f;
        logic         snap_c;
        logic         snap_eq;
        n_total = 0;
        n_bad   = 0;
        rst = 1'b1;
        cmd_valid = 1'b0; res_ready = 1'b0;
        cmd_a = '0; cmd_b = '0; cmd_s = '0; cmd_m = 1'b0; cmd_c_in = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_res_valid", 32'(res_valid),  32'd0);
        check("rst_res_f",     32'(res_f),      32'd0);
        check("rst_res_c",     32'(res_c_out),  32'd1);
        check("rst_res_eq",    32'(res_a_eq_b), 32'd0);
        check("rst_busy",      32'(busy),       32'd0);
        check("rst_cmd_ready", 32'(cmd_ready),  32'd1);
        rst = 1'b0;
        @(posedge clk); #1;

        // res_ready outside DONE does nothing
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        check("idle_ready_valid", 32'(res_valid), 32'd0);
        check("idle_ready_busy",  32'(busy),      32'd0);

        // 1: XOR in logic mode; arithmetic carry still reported
        run_op("xor", 16'hAA55, 16'h55AA, 4'b0110, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b1);
        // 2: A plus carry, ripple across the byte boundary
        run_op("inc", 16'h00FF, 16'h0000, 4'b0000, 1'b0, 1'b0, 16'h0100, 1'b1, 1'b0);
        // 3: A + B overflow
        run_op("add", 16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
        // 4: A - B - 1 equality compare
        run_op("eq",  16'h1234, 16'h1234, 4'b0110, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b1);
        run_op("neq", 16'h1234, 16'h1334, 4'b0110, 1'b0, 1'b1, 16'hFEFF, 1'b1, 1'b0);

        // 5: backpressure with a new command waiting
        exp_q.push_back({16'h0000, 1'b0, 1'b0});
        send_cmd(16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b1);
        wait_result("bp");
        snap_f = res_f; snap_c = res_c_out; snap_eq = res_a_eq_b;
        cmd_a = 16'h00FF; cmd_b = 16'h0000; cmd_s = 4'b0000; cmd_m = 1'b0; cmd_c_in = 1'b0;
        cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_valid",     32'(res_valid),  32'd1);
            check("bp_f",         32'(res_f),      32'(snap_f));
            check("bp_c",         32'(res_c_out),  32'(snap_c));
            check("bp_eq",        32'(res_a_eq_b), 32'(snap_eq));
            check("bp_cmd_ready", 32'(cmd_ready),  32'd0);
        end
        compare_result("bp");
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        check("bp_handshake_valid", 32'(res_valid), 32'd0);
        check("bp_next_ready",      32'(cmd_ready), 32'd1);
        exp_q.push_back({16'h0100, 1'b1, 1'b0});
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        wait_result("bp_next");
        compare_result("bp_next");
        consume("bp_next");

        // 6: reset during byte 1
        send_cmd(16'h1111, 16'h2222, 4'b1001, 1'b0, 1'b1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_valid", 32'(res_valid), 32'd0);
        check("rst_mid_busy",  32'(busy),      32'd0);
        check("rst_mid_f",     32'(res_f),     32'd0);
        check("rst_mid_c",     32'(res_c_out), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            check("rst_mid_no_result", 32'(res_valid), 32'd0);
        end
        run_op("xor_again", 16'hAA55, 16'h55AA, 4'b0110, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b1);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_ula_seq_exec

// File: doc/ula_seq_exec.md
Name: ula_seq_exec

Overview:
- Multi-byte execution sequencer wrapped around the existing 8-bit 74181-style ALU (ula_8_bits).
- Accepts one NBYTES-wide operation over a valid/ready command port.
- Drives the ALU one byte per cycle, LSB byte first, chaining the carry from byte to byte.
- Captures each byte result, then presents the full-width result, carry and equality flag on a valid/ready result port.

Parameters:
- NBYTES, 2, number of 8-bit slices per operation (>=1); W = 8*NBYTES, derived localparam.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_a  in  W  operand A
- cmd_b  in  W  operand B
- cmd_s  in  4  ALU function select
- cmd_m  in  1  mode: 1 = logic, 0 = arithmetic
- cmd_c_in  in  1  carry into byte 0; active-low (0 = carry)
- res_valid  out  1  result present
- res_ready  in  1  consumer takes result
- res_f  out  W  result word
- res_c_out  out  1  carry out of top byte; active-low
- res_a_eq_b  out  1  AND of per-byte a_eq_b
- busy  out  1  state != IDLE

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high, rst.
- ALU carry convention: c_in and c_out are active-low, 74181 convention.
- Reset values:
  - state = IDLE, byte index = 0
  - res_valid = 0, res_f = 0, res_c_out = 1, res_a_eq_b = 0, busy = 0
  - working registers = 0
- cmd_ready is 1 exactly in IDLE and is combinational from state.
- FSM states: IDLE, EXEC, DONE.
  - IDLE: on cmd_valid & cmd_ready:
    - latch a, b, s, m, c_in
    - carry register <= cmd_c_in, eq accumulator <= 1, index <= 0
    - go to EXEC
  - EXEC, one cycle per byte k = index:
    - ALU inputs: a[8k+7:8k], b[8k+7:8k], latched s and m, c_in = carry register.
    - Each cycle: working f byte k <= ALU f; carry register <= ALU c_out; eq <= eq & ALU a_eq_b; index++.
    - On k = NBYTES-1: copy working f, final c_out and final eq into the res_* registers, set res_valid = 1, go to DONE.
  - DONE:
    - Hold res_valid and all res_* stable until res_ready.
    - On res_valid & res_ready: res_valid <= 0, go to IDLE.
    - cmd_ready = 0 in DONE, so no overlap between operations.
- Latency:
  - Command accepted at edge T; res_valid rises at edge T+NBYTES.
  - Minimum issue interval is NBYTES+2 cycles.
- Data stability:
  - Command inputs are don't-care after acceptance.
  - res_f, res_c_out and res_a_eq_b keep their last values after the handshake until the next DONE entry.
- Carry and mode:
  - In logic mode the carry still propagates through the chain; the ALU ignores it. res_c_out is reported regardless.
- NBYTES = 1: EXEC lasts exactly one cycle.
- res_ready asserted while not in DONE is ignored.
- Reset mid-operation:
  - Immediate return to reset values; the partial result is discarded.
  - No result is emitted for the interrupted command.

Decomposition:
- Package ula_pkg holds:
  - state enum typedef (IDLE/EXEC/DONE)
  - ULA_BYTE_W = 8
  - ULA_CARRY_ASSERTED = 1'b0
  - ULA_CARRY_NONE = 1'b1
- Sub-module: exactly one ula_8_bits instance, time-multiplexed across bytes. There is no per-byte replication.
- Index counter width: $clog2(NBYTES), minimum 1.

Test Plan (NBYTES = 2):
1. XOR: m=1, s=0110, a=0xAA55, b=0x55AA, accepted at edge T -> res_valid at T+2, res_f=0xFFFF, busy high T..T+2.
2. Increment with carry across bytes: m=0, s=0000, a=0x00FF, c_in=0 -> res_f=0x0100, res_c_out=1.
3. Add with overflow: m=0, s=1001, a=0xFFFF, b=0x0001, c_in=1 -> res_f=0x0000, res_c_out=0.
4. Equality (m=0, s=0110, c_in=1):
   - a=b=0x1234 -> res_f=0xFFFF, res_a_eq_b=1.
   - a=0x1234, b=0x1334 -> res_a_eq_b=0.
5. Backpressure: hold res_ready=0 for 5 cycles with cmd_valid=1 and a new command present -> res_valid, res_f and flags stable; cmd_ready=0; new command not taken. After the handshake, the new command is accepted on the following edge.
6. Reset mid-EXEC:
   - Assert rst during byte 1 -> same cycle res_valid=0, busy=0, res_f=0, res_c_out=1.
   - After release, run case 1 again -> correct 0xFFFF result with no stale data.
